// File: rtl/grng_stream_ctrl.sv
// grng_stream_ctrl: sequencer and FWFT output FIFO for the ICDF Gaussian generator pipeline
//   clk, rst                      clock, synchronous active-high reset
//   start_i, stop_i               stream control (start honoured in IDLE, stop everywhere else)
//   cfg_seed{1,2,3}_i             seeds latched on an accepted start
//   seed_s{1,2,3}_o               held seeds to the generator
//   gen_rst_o, gen_en_o           generator reset / enable
//   gen_data_i                    generator sample
//   out_data_o, out_valid_o,
//   out_ready_i                   FIFO head, valid/ready handshake
//   busy_o, fifo_level_o,
//   sample_cnt_o                  status
module grng_stream_ctrl #(
   parameter int LAT    = 6,
   parameter int DEPTH  = 16,
   parameter int LOW_WM = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start_i,
   input  logic                     stop_i,
   input  logic [63:0]              cfg_seed1_i,
   input  logic [63:0]              cfg_seed2_i,
   input  logic [63:0]              cfg_seed3_i,
   output logic [63:0]              seed_s1_o,
   output logic [63:0]              seed_s2_o,
   output logic [63:0]              seed_s3_o,
   output logic                     gen_rst_o,
   output logic                     gen_en_o,
   input  logic [15:0]              gen_data_i,
   output logic [15:0]              out_data_o,
   output logic                     out_valid_o,
   input  logic                     out_ready_i,
   output logic                     busy_o,
   output logic [$clog2(DEPTH):0]   fifo_level_o,
   output logic [31:0]              sample_cnt_o
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = LAT > 1 ? $clog2(LAT) : 1;
   typedef enum logic [2:0] {IDLE, SEED, WARM, RUN, PAUSE} state_t;
   state_t state_q, state_d;
   logic [CW-1:0] warm_q, warm_d;
   logic [AW:0] level_q, level_d;
   logic [AW-1:0] wr_q, rd_q;
   logic [15:0] mem_q [DEPTH];
   logic [63:0] s1_q, s2_q, s3_q;
   logic [31:0] cnt_q, cnt_d;
   logic push, pop, accept;
   always_comb begin
      pop = (level_q != '0) && out_ready_i;
      // a restart from IDLE can reach RUN with a full FIFO; only push when there is room
      push = (state_q == RUN) && ((level_q != (AW+1)'(DEPTH)) || pop);
      level_d = level_q + (AW+1)'(push) - (AW+1)'(pop);
      accept = (state_q == IDLE) && start_i && !stop_i;
      cnt_d = accept ? '0 : cnt_q + 32'(push);
      state_d = state_q;
      warm_d = warm_q;
      unique case (state_q)
         IDLE:  state_d = accept ? SEED : IDLE;
         SEED:  begin
            state_d = WARM;
            warm_d = CW'(LAT - 1);
         end
         WARM:  begin
            state_d = (warm_q == '0) ? RUN : WARM;
            warm_d = warm_q - CW'(1);
         end
         RUN:   state_d = (level_d == (AW+1)'(DEPTH)) ? PAUSE : RUN;
         PAUSE: if (level_q <= (AW+1)'(LOW_WM)) begin
            // generator pipeline was flushed when enable dropped: full re-warm
            state_d = WARM;
            warm_d = CW'(LAT - 1);
         end
         default: state_d = IDLE;
      endcase
      if (stop_i && state_q != IDLE) state_d = IDLE;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         warm_q <= '0;
         level_q <= '0;
         wr_q <= '0;
         rd_q <= '0;
         s1_q <= '0;
         s2_q <= '0;
         s3_q <= '0;
         cnt_q <= '0;
      end else begin
         state_q <= state_d;
         warm_q <= warm_d;
         level_q <= level_d;
         wr_q <= wr_q + AW'(push);
         rd_q <= rd_q + AW'(pop);
         cnt_q <= cnt_d;
         if (accept) begin
            s1_q <= cfg_seed1_i;
            s2_q <= cfg_seed2_i;
            s3_q <= cfg_seed3_i;
         end
      end
   end
   always_ff @(posedge clk) if (push) mem_q[wr_q] <= gen_data_i;
   assign seed_s1_o = s1_q;
   assign seed_s2_o = s2_q;
   assign seed_s3_o = s3_q;
   assign gen_rst_o = state_q == SEED;
   assign gen_en_o = (state_q == WARM) || (state_q == RUN);
   assign busy_o = state_q != IDLE;
   assign out_valid_o = level_q != '0;
   assign out_data_o = (level_q != '0) ? mem_q[rd_q] : '0;
   assign fifo_level_o = level_q;
   assign sample_cnt_o = cnt_q;
endmodule

// File: tb/tb_grng_stream_ctrl.sv
// tb_grng_stream_ctrl: directed scoreboard bench for grng_stream_ctrl
module tb_grng_stream_ctrl;
   logic clk = 0, rst = 1, start = 0, stop = 0, out_ready = 0;
   logic [63:0] cfg1 = 0, cfg2 = 0, cfg3 = 0;
   logic [63:0] s1, s2, s3;
   logic gen_rst, gen_en, out_valid, busy;
   logic [15:0] gen_data, out_data;
   logic [4:0] level;
   logic [31:0] cnt;
   int cyc = 0, tests = 0, fails = 0, ecnt = 0;
   logic [15:0] exp_q [$];
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   function automatic logic [15:0] gd(int c);
      return 16'(c * 40503 + 4660);
   endfunction
   assign gen_data = gd(cyc);
   grng_stream_ctrl dut (
      .clk(clk), .rst(rst), .start_i(start), .stop_i(stop),
      .cfg_seed1_i(cfg1), .cfg_seed2_i(cfg2), .cfg_seed3_i(cfg3),
      .seed_s1_o(s1), .seed_s2_o(s2), .seed_s3_o(s3),
      .gen_rst_o(gen_rst), .gen_en_o(gen_en), .gen_data_i(gen_data),
      .out_data_o(out_data), .out_valid_o(out_valid), .out_ready_i(out_ready),
      .busy_o(busy), .fifo_level_o(level), .sample_cnt_o(cnt)
   );
   task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic tick(int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask
   // one RUN cycle: the sample on gen_data now is what the DUT captures at the next edge
   task automatic run(int n);
      repeat (n) begin
         exp_q.push_back(gd(cyc));
         tick();
         ecnt++;
         chk("sample_cnt", cnt, 64'(ecnt));
      end
   endtask
   // consumer side: every accepted word must be the next expected sample
   always @(negedge clk)
      if (!rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) chk("pop_unexpected", 64'(out_data), 64'hDEAD_BEEF);
         else chk("data", 64'(out_data), 64'(exp_q.pop_front()));
      end
   task automatic warm_up(bit any_valid);
      tick();
      chk("seed_gen_rst", gen_rst, 1);
      chk("seed_gen_en", gen_en, 0);
      chk("seed_busy", busy, 1);
      chk("seed_cnt_clear", cnt, 0);
      start = 0;
      ecnt = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("warm_gen_en", gen_en, 1);
         chk("warm_gen_rst", gen_rst, 0);
         if (!any_valid) chk("warm_no_valid", out_valid, 0);
      end
      tick();
      chk("run_gen_en", gen_en, 1);
   endtask
   initial begin
      tick(2);
      rst = 0;
      chk("rst_gen_rst", gen_rst, 0);
      chk("rst_gen_en", gen_en, 0);
      chk("rst_busy", busy, 0);
      chk("rst_valid", out_valid, 0);
      chk("rst_data", out_data, 0);
      chk("rst_level", level, 0);
      chk("rst_cnt", cnt, 0);
      chk("rst_seed", s1 | s2 | s3, 0);
      // streaming with a ready consumer
      cfg1 = 64'h1; cfg2 = 64'h2; cfg3 = 64'h3;
      start = 1; out_ready = 1;
      warm_up(0);
      chk("seed1", s1, 1);
      chk("seed2", s2, 2);
      chk("seed3", s3, 3);
      chk("first_valid_early", out_valid, 0);
      run(1);
      chk("first_valid", out_valid, 1);
      run(7);
      chk("steady_level", level, 1);
      // start while running is ignored
      cfg1 = 64'hAA; start = 1;
      run(1);
      start = 0;
      chk("run_start_ignored", s1, 1);
      // stop with 5 buffered: stop-cycle push still lands
      out_ready = 0;
      run(4);
      chk("pre_stop_level", level, 5);
      stop = 1;
      run(1);
      stop = 0;
      chk("stop_busy", busy, 0);
      chk("stop_gen_en", gen_en, 0);
      chk("stop_level", level, 6);
      out_ready = 1;
      tick(6);
      chk("drain_valid", out_valid, 0);
      chk("drain_data", out_data, 0);
      chk("drain_sb", exp_q.size(), 0);
      // start and stop together: stop wins
      cfg1 = 64'h55; start = 1; stop = 1;
      tick();
      start = 0; stop = 0;
      chk("ss_busy", busy, 0);
      chk("ss_gen_rst", gen_rst, 0);
      chk("ss_seed", s1, 1);
      // fill to DEPTH, pause, drain 12, re-warm
      cfg1 = 64'h11; cfg2 = 64'h22; cfg3 = 64'h33;
      start = 1; out_ready = 0;
      warm_up(0);
      chk("seed1_b", s1, 64'h11);
      chk("seed3_b", s3, 64'h33);
      run(16);
      chk("full_level", level, 16);
      chk("pause_gen_en", gen_en, 0);
      chk("pause_busy", busy, 1);
      tick(2);
      chk("hold_level", level, 16);
      chk("hold_cnt", cnt, 16);
      out_ready = 1;
      tick(12);
      out_ready = 0;
      chk("low_level", level, 4);
      chk("low_gen_en", gen_en, 0);
      tick();
      chk("rewarm_gen_en", gen_en, 1);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("rewarm_level", level, 4);
         chk("rewarm_en", gen_en, 1);
      end
      tick();
      chk("resume_level", level, 4);
      chk("resume_cnt", cnt, 16);
      run(3);
      chk("resume_fill", level, 7);
      stop = 1; out_ready = 1;
      run(1);
      stop = 0;
      chk("stop2_level", level, 7);
      tick(7);
      chk("drain2_valid", out_valid, 0);
      chk("drain2_sb", exp_q.size(), 0);
      // reset mid-run with 9 buffered
      cfg1 = 64'h7; start = 1; out_ready = 0;
      warm_up(0);
      run(9);
      chk("pre_rst_level", level, 9);
      exp_q.delete();
      rst = 1;
      tick();
      rst = 0;
      chk("mrst_level", level, 0);
      chk("mrst_valid", out_valid, 0);
      chk("mrst_data", out_data, 0);
      chk("mrst_busy", busy, 0);
      chk("mrst_gen_en", gen_en, 0);
      chk("mrst_gen_rst", gen_rst, 0);
      chk("mrst_seed", s1, 0);
      chk("mrst_cnt", cnt, 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
endmodule

// File: doc/grng_stream_ctrl.md
Name: grng_stream_ctrl

Overview:
- Sequencer and output buffer for the ICDF Gaussian generator pipeline (taus URNG -> LZD/mask -> coef ROM -> Mul18_Add18 -> Mul18_Add21 -> sign mux).
- Seeds and resets the generator, runs its fixed-latency warm-up, and captures one sample per cycle into a FIFO with a valid/ready output.
- Dropping the generator enable clears its pipeline. On backpressure the block therefore pauses the generator and re-warms it before capturing again; warm-up samples are never forwarded.

Parameters:
- LAT, 6, generator enable-to-first-valid-sample latency in cycles (min 1).
- DEPTH, 16, output FIFO depth in samples (power of 2, >= 4).
- LOW_WM, 4, FIFO level at or below which a paused generator is restarted (< DEPTH).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin streaming; honoured in IDLE only.
- stop  in  1  end streaming; honoured in any state except IDLE.
- cfg_seed1  in  64  seed S1, captured on an accepted start.
- cfg_seed2  in  64  seed S2, captured on an accepted start.
- cfg_seed3  in  64  seed S3, captured on an accepted start.
- seed_s1  out  64  held seed S1 to the generator.
- seed_s2  out  64  held seed S2 to the generator.
- seed_s3  out  64  held seed S3 to the generator.
- gen_rst  out  1  generator synchronous reset (loads seeds).
- gen_en  out  1  generator enable (en_icdf).
- gen_data  in  16  generator signed sample (gauss_rng).
- out_data  out  16  FIFO head sample (first-word-fall-through).
- out_valid  out  1  FIFO not empty.
- out_ready  in  1  consumer accepts out_data.
- busy  out  1  state != IDLE.
- fifo_level  out  clog2(DEPTH)+1  current FIFO occupancy.
- sample_cnt  out  32  samples pushed since the last accepted start; wraps at 2^32.

Behaviour:
- Reset: state=IDLE; FIFO emptied; seeds=0; gen_rst=0; gen_en=0; out_valid=0; out_data=0; fifo_level=0; sample_cnt=0; busy=0. Reset applied mid-run discards all buffered data.
- Moore outputs decoded from registered state: gen_rst=1 only in SEED; gen_en=1 only in WARM and RUN.
- IDLE: on start && !stop, latch cfg_seed1..3 into seed_s1..3, clear sample_cnt, go to SEED. If start && stop arrive together, stop wins and the block stays in IDLE. start in any other state is ignored.
- SEED: lasts exactly 1 cycle, then WARM.
- WARM: lasts exactly LAT cycles. The warm counter loads LAT-1 on entry and exits at 0 to RUN. No pushes occur in WARM.
- RUN: push gen_data every cycle, sample_cnt += 1 per push.
  - next_level = level + push - pop.
  - If next_level == DEPTH, go to PAUSE; gen_en goes 0 the following cycle. The FIFO can never overflow.
- PAUSE: no pushes. When level <= LOW_WM, go to WARM. The generator pipeline has been cleared, so a full LAT re-warm is mandatory.
- stop in SEED/WARM/RUN/PAUSE: go to IDLE the next cycle. A RUN-state push in the stop cycle still occurs. The FIFO is retained and keeps draining in IDLE.
- FIFO:
  - pop = out_valid && out_ready. Simultaneous push and pop leave the level unchanged.
  - out_data is the head entry; out_data=0 when empty.
  - Order is preserved. Wrap-around is via clog2(DEPTH)-bit pointers.
- Latency: the first sample pushed is the generator output in the cycle after the last WARM cycle. It is visible on out_data 1 cycle after the push.

Test Plan:
- Reset, then start with seeds 0x1/0x2/0x3, out_ready=1 -> gen_rst high for 1 cycle; gen_en high from the next cycle; first out_valid exactly LAT+2 cycles after SEED; sample_cnt increments by 1 per cycle thereafter.
- DEPTH=16, out_ready=0 after start -> exactly 16 pushes, fifo_level=16, PAUSE entered; gen_en=0; no overflow; sample_cnt=16.
- From the full/paused state, pop 12 with out_ready=1 -> on fifo_level=4, re-WARM for 6 cycles; then pushes resume; the popped sequence is exactly the 16 captured samples in order.
- start and stop asserted together in IDLE -> remains IDLE, busy=0, seeds unchanged. start asserted in RUN -> ignored.
- stop mid-RUN with 5 samples buffered -> IDLE next cycle; gen_en=0; the remaining 5 or 6 samples (including the stop-cycle push) drain; out_valid then falls.
- rst asserted mid-RUN with 9 samples buffered -> next cycle fifo_level=0, out_valid=0, all outputs at their reset values.
